// File: rtl/ct_f_spsram_pkg.sv
// Shared types and constants for the single-port SRAM request controller.
// Optional build macro: CT_F_SPSRAM_INIT_EN (zero-fill sweep after reset).
package ct_f_spsram_pkg;

    // Controller state: INIT only reachable when the zero-fill sweep is built in
    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    // Occupancy counter width: reads in flight plus buffered responses, up to 7
    localparam int unsigned OCC_W = 3;

    localparam int unsigned FIFO_DEPTH_MIN = 2;
    localparam int unsigned FIFO_DEPTH_MAX = 7;

    function automatic bit fifo_depth_legal(input int unsigned depth);
        return (depth >= FIFO_DEPTH_MIN) && (depth <= FIFO_DEPTH_MAX);
    endfunction

endpackage

// File: rtl/ct_f_spsram_rsp_fifo.sv
// In-order response FIFO for SRAM read data. Head entry is read straight from
// the storage registers, so pop_data stays stable until the entry is popped.
module ct_f_spsram_rsp_fifo
    import ct_f_spsram_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned DEPTH      = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  full,
    output logic                  empty,
    output logic [OCC_W-1:0]      count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q;
    logic [PTR_W-1:0]      rd_ptr_q;
    logic [OCC_W-1:0]      count_q;
    logic [OCC_W-1:0]      count_d;
    logic                  do_push;
    logic                  do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full     = (count_q == OCC_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // Entry count next-state: simultaneous push and pop leave it unchanged
    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    // Data storage; contents need no reset since count gates visibility
    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/ct_f_spsram_req_ctrl.sv
// Request/response front-end for the single-port SRAM wrapper: maps a
// valid/ready request channel onto the macro's active-low pins and buffers
// read data in a credit-protected response FIFO.
// Optional build macro: CT_F_SPSRAM_INIT_EN zero-fills the array after reset.
module ct_f_spsram_req_ctrl
    import ct_f_spsram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  idle,
    output logic [ADDR_WIDTH-1:0] A,
    output logic                  CEN,
    output logic                  GWEN,
    output logic [DATA_WIDTH-1:0] WEN,
    output logic [DATA_WIDTH-1:0] D,
    input  logic [DATA_WIDTH-1:0] Q
);

    localparam bit DEPTH_OK = fifo_depth_legal(FIFO_DEPTH);

`ifdef CT_F_SPSRAM_INIT_EN
    localparam state_e RESET_STATE = StInit;
    logic [ADDR_WIDTH-1:0] init_cnt_q;
`else
    localparam state_e RESET_STATE = StRun;
`endif

    state_e           state_q;
    state_e           state_d;
    logic [OCC_W-1:0] occ_q;
    logic [OCC_W-1:0] occ_d;
    logic             rd_pend_q;
    logic             acc;
    logic             rd_acc;
    logic             rsp_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OCC_W-1:0] fifo_count;

    // Credit check uses registered occupancy only, so rsp_rdy never reaches req_rdy
    assign req_rdy = !RST && (state_q == StRun) && (occ_q < OCC_W'(FIFO_DEPTH));
    assign acc     = req_vld && req_rdy;
    assign rd_acc  = acc && !req_wr;
    assign rsp_vld = !fifo_empty && !RST;
    assign rsp_pop = rsp_vld && rsp_rdy;
    assign idle    = (state_q == StRun) && (occ_q == '0);

`ifdef CT_F_SPSRAM_INIT_EN
    assign init_done = !RST && (state_q == StRun);
`else
    assign init_done = !RST;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= RESET_STATE;
        else     state_q <= state_d;
    end

    // Next state: leave INIT once the last address has been written
    always_comb begin
        state_d = state_q;
`ifdef CT_F_SPSRAM_INIT_EN
        if ((state_q == StInit) && (init_cnt_q == '1)) state_d = StRun;
`endif
    end

`ifdef CT_F_SPSRAM_INIT_EN
    // Sweep address counter; reset restarts the sweep at address 0
    always_ff @(posedge CLK) begin
        if (RST)                    init_cnt_q <= '0;
        else if (state_q == StInit) init_cnt_q <= init_cnt_q + 1'b1;
    end
`endif

    // Occupancy next-state: accepted read adds a credit, popped response returns it
    always_comb begin
        occ_d = occ_q;
        case ({rd_acc, rsp_pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Occupancy and read-pending registers; reset discards outstanding reads
    always_ff @(posedge CLK) begin
        if (RST) begin
            occ_q     <= '0;
            rd_pend_q <= 1'b0;
        end else begin
            occ_q     <= occ_d;
            rd_pend_q <= rd_acc;
        end
    end

    // SRAM pin mapping, flow-through from the request channel
    always_comb begin
        A    = req_addr;
        D    = req_wdata;
        CEN  = 1'b1;
        GWEN = 1'b1;
        WEN  = '1;
        if (RST) begin
            // Pins stay deselected; any request presented now is dropped
        end
`ifdef CT_F_SPSRAM_INIT_EN
        else if (state_q == StInit) begin
            A    = init_cnt_q;
            D    = '0;
            CEN  = 1'b0;
            GWEN = 1'b0;
            WEN  = '0;
        end
`endif
        else begin
            CEN  = !acc;
            GWEN = !(acc && req_wr);
            WEN  = (acc && req_wr) ? ~req_wmask : '1;
        end
    end

    ct_f_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH)
    ) u_rsp_fifo (
        .CLK       (CLK),
        .RST       (RST),
        .push      (rd_pend_q),
        .push_data (Q),
        .pop       (rsp_pop),
        .pop_data  (rsp_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Invariants: legal depth, credits prevent overflow, occ tracks pending + buffered
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (DEPTH_OK);
            assert (!(rd_pend_q && fifo_full));
            assert (occ_q == fifo_count + {{(OCC_W - 1){1'b0}}, rd_pend_q});
        end
    end

endmodule

// File: doc/ct_f_spsram_req_ctrl.md
Name: ct_f_spsram_req_ctrl

Overview:
Request/response front-end for the 1024x128 FPGA single-port SRAM wrapper. Converts a valid/ready request channel (read/write, bit-masked) into the macro's active-low pins (CEN/GWEN/WEN), and captures read data into a small response FIFO. Credit-based flow control guarantees that read data is never lost under response backpressure. Sits directly upstream of the SRAM wrapper; the response side feeds the consumer.

Parameters:
ADDR_WIDTH, 10, SRAM address width (depth 2^ADDR_WIDTH)
DATA_WIDTH, 128, data/mask width
FIFO_DEPTH, 3, response FIFO entries; legal range 2..7; 3 sustains one read per cycle

Ports:
CLK  in  1  clock, same as SRAM CLK
RST  in  1  synchronous reset, active-high
req_vld  in  1  request valid
req_rdy  out  1  request ready
req_wr  in  1  1=write, 0=read
req_addr  in  ADDR_WIDTH  request address
req_wdata  in  DATA_WIDTH  write data
req_wmask  in  DATA_WIDTH  write bit-enables, active-high
rsp_vld  out  1  read data valid
rsp_rdy  in  1  consumer ready
rsp_rdata  out  DATA_WIDTH  read data
init_done  out  1  array usable
idle  out  1  no reads in flight or buffered, FSM in RUN
A  out  ADDR_WIDTH  to SRAM A
CEN  out  1  to SRAM CEN, active-low
GWEN  out  1  to SRAM GWEN, active-low
WEN  out  DATA_WIDTH  to SRAM WEN, active-low per bit
D  out  DATA_WIDTH  to SRAM D

Behaviour:
- Clock CLK, single domain; reset RST synchronous, active-high.
- acc = req_vld && req_rdy. In RUN: CEN = !acc; A = req_addr; D = req_wdata; GWEN = !(acc && req_wr); WEN = ~req_wmask for writes, all-ones otherwise. Flow-through; no added latency on the request side.
- occ (3-bit) = reads in flight + FIFO entries. +1 on an accepted read, -1 on rsp_vld && rsp_rdy; simultaneous events leave occ unchanged.
- req_rdy = (state==RUN) && (occ < FIFO_DEPTH); registered occ only, no rsp_rdy->req_rdy combinational path. Writes are gated by the same ready but do not change occ.
- Read accepted in cycle N: SRAM Q valid in N+1, pushed into the FIFO at the end of N+1, rsp_vld=1 in N+2. Read-to-response latency is 2 cycles.
- rd_pend flag: set on accepted read, captures Q next cycle. The credit rule guarantees the FIFO is never full on a push. Push with FIFO full is an assertion failure.
- FIFO is in-order with a registered head; rsp_rdata holds stable while rsp_vld && !rsp_rdy. Push and pop in the same cycle are both legal, including when the FIFO is empty-then-pushed (no bypass; data appears the cycle after push).
- Write followed by read of the same address in the next cycle returns the new data (SRAM ordering); no hazard logic.
- FSM states: INIT, RUN. INIT exists only with the optional feature; otherwise the reset state is RUN.
- Reset values: req_rdy=0 during RST, rsp_vld=0, occ=0, rd_pend=0, FIFO pointers=0, CEN=1, GWEN=1, WEN=all-ones, init_done per feature, idle=0 in INIT else 1.
- Reset mid-operation: in-flight and buffered reads are discarded, with no response issued. A write in the reset cycle is not issued (CEN forced 1 while RST).

Optional Feature:
CT_F_SPSRAM_INIT_EN
- Defined: reset enters INIT. A 10-bit sweep counter writes zero to addresses 0..2^ADDR_WIDTH-1, one per cycle (CEN=0, GWEN=0, WEN=0, D=0). After the last address the FSM moves to RUN, so init_done=1 exactly 2^ADDR_WIDTH cycles after RST deasserts. req_rdy=0 throughout INIT. RST during INIT restarts the sweep at 0.
- Undefined: no counter; RUN from reset; init_done=1 in every cycle RST is low.

Decomposition:
- Package ct_f_spsram_pkg: state enum (INIT, RUN); localparams for occ width and the FIFO_DEPTH legality check.
- Sub-module ct_f_spsram_rsp_fifo: FIFO_DEPTH x DATA_WIDTH, push/pop/full/empty/count. The top level holds the FSM, occ, rd_pend and pin mapping.

Test Plan:
- Write addr 0x005 data 0xA5..A5 mask all-ones, then read 0x005 -> rsp_vld 2 cycles after read accept, rsp_rdata 0xA5..A5.
- Masked write: mask 0x00..00FF, data 0x11..11 over an existing 0xA5..A5 -> WEN=0xFF..FF00 on the pins; readback per wrapper semantics checked against the model.
- 16 back-to-back reads, rsp_rdy=1 -> req_rdy stays 1, one response per cycle, in address order.
- rsp_rdy=0 with streaming reads -> req_rdy drops when occ=3, exactly 3 responses buffered, none lost. Releasing rsp_rdy drains them in order.
- RST for 1 cycle with 2 reads outstanding -> rsp_vld=0 next cycle, occ=0, no stale response afterwards.
- With CT_F_SPSRAM_INIT_EN defined -> init_done rises 1024 cycles after reset, any read then returns 0; RST at sweep address 0x200 restarts the sweep.
